pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline sequencer for the pipelined RV64 core.
- Drives stall and flush controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register.
- Detects load-use hazards, branch/jump redirects and instruction/data memory waits.
- Inserts bubbles after reset, because the pipeline registers themselves have no reset.

Parameters:
- RST_FLUSH_CYCLES, 3: number of cycles after reset release during which all pipeline registers are flushed.
- REG_ADDR_W, 5: register-index width.
- MEM_TIMEOUT, 1024: maximum consecutive dmem_busy cycles before the mem_timeout error is raised.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk, input, 1: core clock.
- rst, input, 1: synchronous reset, active-high.
- id_rs1, input, REG_ADDR_W: decode-stage source register 1.
- id_rs2, input, REG_ADDR_W: decode-stage source register 2.
- id_uses_rs1, input, 1: decode instruction reads rs1.
- id_uses_rs2, input, 1: decode instruction reads rs2.
- ex_rd, input, REG_ADDR_W: EX-stage destination register.
- ex_mem_read, input, 1: EX-stage instruction is a load.
- ex_redirect, input, 1: EX resolved a taken branch or jump.
- imem_ready, input, 1: fetch data valid this cycle.
- dmem_busy, input, 1: data memory not ready; MEM stage must hold.
- pc_stall, output, 1: hold the PC.
- ifid_stall, output, 1: hold the IF/ID register.
- ifid_flush, output, 1: load a NOP into IF/ID.
- idex_stall, output, 1: hold the ID/EX register.
- idex_flush, output, 1: load a bubble into ID/EX.
- exmem_stall, output, 1: hold the EX/MEM register.
- ctrl_state, output, 2: current FSM state, for debug.
- mem_timeout, output, 1: sticky data-memory timeout error.

Behaviour:
- Reset: clk and rst as named. Reset is synchronous and active-high; it is sampled only on the posedge of clk.
- While rst=1, outputs are: pc_stall=1, ifid_flush=1, idex_flush=1, exmem_stall=0, ifid_stall=0, idex_stall=0, mem_timeout=0, state=INIT.
- Internal counters clear to 0 on reset.
- FSM states and encodings: INIT=0, RUN=1, MEM_WAIT=2.
- INIT:
  - Counts RST_FLUSH_CYCLES cycles after rst falls.
  - Outputs stay as during reset for that whole period.
  - After the last flush cycle, moves to RUN.
- RUN: control outputs are combinational from the inputs, with this priority (highest first):
  1. dmem_busy=1: freeze. pc_stall, ifid_stall, idex_stall and exmem_stall are all 1; flushes are 0. Next state is MEM_WAIT.
  2. ex_redirect=1: ifid_flush=1, idex_flush=1, no stalls. The PC takes the redirect target.
  3. Load-use hazard: ex_mem_read=1, ex_rd≠0, and (id_uses_rs1 with id_rs1==ex_rd, or id_uses_rs2 with id_rs2==ex_rd). Response: pc_stall=1, ifid_stall=1, idex_flush=1. This is exactly one bubble per occurrence.
  4. imem_ready=0: pc_stall=1, ifid_flush=1. The stage behind fetch drains normally.
  5. Otherwise all outputs are 0.
- MEM_WAIT:
  - Freeze outputs, as in priority 1, are held while dmem_busy=1.
  - A wait counter increments each cycle.
  - When the counter reaches MEM_TIMEOUT, mem_timeout is set and stays set until rst; the FSM still remains in MEM_WAIT while busy.
  - When dmem_busy=0, outputs are evaluated with the RUN rules in that same cycle, the wait counter clears, and the next state is RUN.
- Simultaneous events:
  - A redirect during a freeze is ignored. The branch is still in EX when the freeze ends and is acted on then.
  - When redirect and load-use are both present, the redirect wins; no bubble is counted for the load-use.
- Register x0 never causes a hazard.
- rst asserted mid-operation returns to INIT on the next edge, regardless of state.
- A stall and a flush on the same register are never asserted together.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall_cycles[CNT_W] and perf_flush_count[CNT_W].
  - perf_stall_cycles increments each cycle pc_stall=1 while in RUN or MEM_WAIT.
  - perf_flush_count increments on each ex_redirect that is acted on.
  - Both counters clear on rst and wrap modulo 2^CNT_W.
- When undefined: these ports and the counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - the state encodings INIT, RUN and MEM_WAIT;
  - REG_ADDR_W;
  - the X0 constant.
- One sub-module, hazard_detect_unit: purely combinational load-use comparator, output load_use.

Test Plan:
- Reset: rst high for 2 cycles, then low → pc_stall and both flushes stay high for exactly 3 further cycles, then ctrl_state=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → a single cycle of pc_stall=1, ifid_stall=1, idex_flush=1. With ex_rd=0 under the same inputs → no stall.
- Redirect with load-use: ex_redirect=1 in the same cycle as a load-use → ifid_flush=1, idex_flush=1, pc_stall=0.
- Memory wait: dmem_busy high for 10 cycles with ex_redirect=1 → all four stalls high for 10 cycles, no flush. On the cycle busy falls, both flushes go high.
- Timeout: MEM_TIMEOUT=8 with dmem_busy held 20 cycles → mem_timeout rises after the 8th busy cycle in MEM_WAIT and stays high after busy drops; only rst clears it.
- Performance counters (HAZARD_PERF_CNT_EN defined): 3 load-use events plus 2 redirects → perf_stall_cycles=3, perf_flush_count=2.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM encodings, register
// index width, the x0 constant and the bundle of stall/flush controls.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  // One field per pipeline control line, in a fixed order.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Pipeline registers have no reset, so bubbles are forced in instead.
  localparam ctrl_t CTRL_RESET = '{pc_stall: 1'b1, ifid_stall: 1'b0,
                                   ifid_flush: 1'b1, idex_stall: 1'b0,
                                   idex_flush: 1'b1, exmem_stall: 1'b0};

  // Data memory not ready: everything in front of MEM holds.
  localparam ctrl_t CTRL_FREEZE = '{pc_stall: 1'b1, ifid_stall: 1'b1,
                                    ifid_flush: 1'b0, idex_stall: 1'b1,
                                    idex_flush: 1'b0, exmem_stall: 1'b1};

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use comparator: the instruction in decode reads a register that the
// load currently in EX has not produced yet. x0 never creates a dependency.
module hazard_detect_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  assign load_use = ex_mem_read && (ex_rd != X0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: flushes the un-reset pipeline registers after
// reset, then resolves data-memory freezes, redirects, load-use bubbles and
// fetch waits. Optional performance counters: define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 3,
  parameter int MEM_TIMEOUT      = 1024
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W          = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic [1:0]            ctrl_state,
  output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    perf_stall_cycles
  , output logic [CNT_W-1:0]    perf_flush_count
`endif
);

  localparam int INIT_W = $clog2(RST_FLUSH_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_e        state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic               load_use;
  logic               redirect_taken;
  ctrl_t              ctrl;

  hazard_detect_unit u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // Next-state, counters and the priority-ordered control decision.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    ctrl           = CTRL_NONE;
    redirect_taken = 1'b0;

    case (state_q)
      INIT: begin
        ctrl = CTRL_RESET;
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          state_d    = RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN, MEM_WAIT: begin
        if (dmem_busy) begin
          // Redirects are ignored here; the branch stays in EX until thaw.
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          if (state_q == MEM_WAIT) begin
            // Saturate so a long hang cannot wrap the counter.
            if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          if (ex_redirect) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            redirect_taken  = 1'b1;
          end else if (load_use) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_stall = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (!imem_ready) begin
            ctrl.pc_stall   = 1'b1;
            ctrl.ifid_flush = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Reset overrides the outputs directly so they are valid while rst is high.
  always_comb begin
    ctrl_t out_c;
    out_c       = rst ? CTRL_RESET : ctrl;
    pc_stall    = out_c.pc_stall;
    ifid_stall  = out_c.ifid_stall;
    ifid_flush  = out_c.ifid_flush;
    idex_stall  = out_c.idex_stall;
    idex_flush  = out_c.idex_flush;
    exmem_stall = out_c.exmem_stall;
    ctrl_state  = rst ? INIT : state_q;
    mem_timeout = timeout_q && !rst;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Stall cycles outside INIT and redirects acted on; both wrap freely.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ctrl.pc_stall && (state_q == RUN || state_q == MEM_WAIT))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_taken)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle RUN
// vectors plus hand-written reset, freeze, timeout and counter sequences.
module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int TB_MEM_TIMEOUT = 8;

  // Expected control bits, order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_RST  = 6'b101010;
  localparam logic [5:0] E_LU   = 6'b110010;
  localparam logic [5:0] E_RED  = 6'b001010;
  localparam logic [5:0] E_IMEM = 6'b101000;
  localparam logic [5:0] E_FRZ  = 6'b110101;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       mrd, redir, imr, busy;
    logic [5:0] e_ctrl;
    logic [1:0] e_st;
    logic       e_to;
  } vec_t;

  typedef struct packed {
    logic [5:0] c;
    logic [1:0] s;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, imem_ready, dmem_busy;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic [1:0] ctrl_state;
  logic mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  exp_t  sb_q[$];
  string sb_name[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .RST_FLUSH_CYCLES (3),
    .MEM_TIMEOUT      (TB_MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .dmem_busy   (dmem_busy),
    .pc_stall    (pc_stall),
    .ifid_stall  (ifid_stall),
    .ifid_flush  (ifid_flush),
    .idex_stall  (idex_stall),
    .idex_flush  (idex_flush),
    .exmem_stall (exmem_stall),
    .ctrl_state  (ctrl_state),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles (perf_stall_cycles)
    , .perf_flush_count  (perf_flush_count)
`endif
  );

  function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] exrd, logic mrd,
                              logic redir, logic imr, logic busy,
                              logic [5:0] e_ctrl, logic [1:0] e_st, logic e_to);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.exrd = exrd; v.mrd = mrd; v.redir = redir; v.imr = imr; v.busy = busy;
    v.e_ctrl = e_ctrl; v.e_st = e_st; v.e_to = e_to;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic apply(input vec_t v);
    exp_t e, got;
    string nm;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.exrd; ex_mem_read = v.mrd; ex_redirect = v.redir;
    imem_ready = v.imr; dmem_busy = v.busy;
    sb_q.push_back('{c: v.e_ctrl, s: v.e_st, t: v.e_to});
    sb_name.push_back(v.name);
    @(negedge clk);
    got = '{c: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall},
            s: ctrl_state, t: mem_timeout};
    e  = sb_q.pop_front();
    nm = sb_name.pop_front();
    check(nm, 32'(got), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [5:0] ec, input logic [1:0] es, input logic et);
    apply(mk(name, 0, 0, 0, 0, 0, 0, 0, 1, 0, ec, es, et));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle("rst_hold", E_RST, INIT, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle("init_flush", E_RST, INIT, 1'b0);
    idle("run_entry", E_NONE, RUN, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk("idle",            0, 0, 0, 0, 0, 0, 0, 1, 0, E_NONE, RUN, 0));
    tbl.push_back(mk("lu_rs2",          3, 5, 1, 1, 5, 1, 0, 1, 0, E_LU,   RUN, 0));
    tbl.push_back(mk("lu_single",       0, 0, 0, 0, 0, 0, 0, 1, 0, E_NONE, RUN, 0));
    tbl.push_back(mk("lu_rd_x0",        0, 0, 1, 1, 0, 1, 0, 1, 0, E_NONE, RUN, 0));
    tbl.push_back(mk("lu_rs1",          7, 2, 1, 1, 7, 1, 0, 1, 0, E_LU,   RUN, 0));
    tbl.push_back(mk("rs1_unused",      7, 2, 0, 1, 7, 1, 0, 1, 0, E_NONE, RUN, 0));
    tbl.push_back(mk("not_load",        7, 2, 1, 1, 7, 0, 0, 1, 0, E_NONE, RUN, 0));
    tbl.push_back(mk("redir_over_lu",   3, 5, 1, 1, 5, 1, 1, 1, 0, E_RED,  RUN, 0));
    tbl.push_back(mk("imem_wait",       0, 0, 0, 0, 0, 0, 0, 0, 0, E_IMEM, RUN, 0));
    tbl.push_back(mk("lu_over_imem",    3, 5, 1, 1, 5, 1, 0, 0, 0, E_LU,   RUN, 0));
    tbl.push_back(mk("redir_over_imem", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_RED,  RUN, 0));
    tbl.push_back(mk("idle_end",        0, 0, 0, 0, 0, 0, 0, 1, 0, E_NONE, RUN, 0));

    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_redirect = 0;
    imem_ready = 1; dmem_busy = 0;
    @(posedge clk);
    #1;

    // Reset held two cycles, three flush cycles after release, then RUN.
    idle("rst_hold", E_RST, INIT, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle("init_flush", E_RST, INIT, 1'b0);
    idle("run_entry", E_NONE, RUN, 1'b0);

    // Single-cycle RUN priority table.
    foreach (tbl[i]) apply(tbl[i]);

    // Freeze for 10 cycles with a pending redirect; 9 MEM_WAIT cycles exceed the timeout of 8.
    for (int i = 1; i <= 10; i++)
      apply(mk("mem_freeze", 0, 0, 0, 0, 0, 0, 1, 1, 1, E_FRZ,
               (i == 1) ? RUN : MEM_WAIT, i >= TB_MEM_TIMEOUT + 2));
    apply(mk("thaw_redirect", 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RED, MEM_WAIT, 1));
    idle("after_thaw", E_NONE, RUN, 1'b1);

    // Reset in the middle of a freeze returns to INIT and clears the error.
    apply(mk("busy_pre_rst", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, RUN, 1));
    apply(mk("busy_pre_rst", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ, MEM_WAIT, 1));
    rst = 1'b1;
    apply(mk("rst_mid_freeze", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RST, INIT, 0));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle("init_after_mid", E_RST, INIT, 1'b0);
    idle("run_after_mid", E_NONE, RUN, 1'b0);

    // Timeout: busy 20 cycles, error rises after the 8th MEM_WAIT cycle and sticks.
    for (int i = 1; i <= 20; i++)
      apply(mk("timeout_busy", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_FRZ,
               (i == 1) ? RUN : MEM_WAIT, i >= TB_MEM_TIMEOUT + 2));
    idle("timeout_thaw", E_NONE, MEM_WAIT, 1'b1);
    for (int i = 0; i < 3; i++) idle("timeout_sticky", E_NONE, RUN, 1'b1);
    do_reset();

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(mk("perf_lu", 3, 5, 1, 1, 5, 1, 0, 1, 0, E_LU, RUN, 0));
      idle("perf_gap", E_NONE, RUN, 1'b0);
    end
    for (int i = 0; i < 2; i++)
      apply(mk("perf_redir", 0, 0, 0, 0, 0, 0, 1, 1, 0, E_RED, RUN, 0));
    idle("perf_idle", E_NONE, RUN, 1'b0);
    @(negedge clk);
    check("perf_stall_cycles", perf_stall_cycles, 32'd3);
    check("perf_flush_count",  perf_flush_count,  32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
